// File: rtl/key_irq_debounce_if.sv
// Processor-side register bus of the debounced key port: a single-cycle read/write strobe
// interface with registered read data.
interface key_irq_debounce_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );
endinterface

// File: rtl/key_irq_debounce.sv
// Debounced active-low pushbutton port with a PIO-compatible register map and level irq.
// Define KEY_IRQ_RELEASE_EDGE_EN to also capture release edges in EDGECAPTURE.
module key_irq_debounce #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n_i,
  key_irq_debounce_if.slave   bus,
  output logic                irq_o,
  output logic [NUM_KEYS-1:0] key_state_o
);

  localparam int unsigned RD_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_DIR  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [NUM_KEYS-1:0]            sync1_q, sync2_q;
  logic [NUM_KEYS-1:0]            stable_q, stable_d;
  logic [NUM_KEYS-1:0]            stable_prev_q;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]            mask_q, mask_d;
  logic [NUM_KEYS-1:0]            edge_q, edge_d;
  logic [RD_W-1:0]                rdata_q, rdata_d;
  logic [NUM_KEYS-1:0]            sync_c;
  logic [NUM_KEYS-1:0]            edge_det_c;
  logic [NUM_KEYS-1:0]            w1c_c;
  logic                           unused_wdata;

  assign sync_c       = ~sync2_q;
  assign unused_wdata = ^bus.writedata[RD_W-1:NUM_KEYS];

`ifdef KEY_IRQ_RELEASE_EDGE_EN
  assign edge_det_c = stable_q ^ stable_prev_q;
`else
  assign edge_det_c = stable_q & ~stable_prev_q;
`endif

  // A differing level must persist for DEBOUNCE_CYCLES consecutive cycles to be accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (sync_c[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register file; a newly detected edge overrides a simultaneous W1C of the same bit.
  always_comb begin
    mask_d  = mask_q;
    w1c_c   = '0;
    rdata_d = rdata_q;
    if (bus.write && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[NUM_KEYS-1:0];
    end
    if (bus.write && (bus.address == ADDR_EDGE)) begin
      w1c_c = bus.writedata[NUM_KEYS-1:0];
    end
    edge_d = (edge_q & ~w1c_c) | edge_det_c;
    if (bus.read) begin
      unique case (bus.address)
        ADDR_DATA: rdata_d = RD_W'(stable_q);
        ADDR_DIR:  rdata_d = '0;
        ADDR_MASK: rdata_d = RD_W'(mask_q);
        ADDR_EDGE: rdata_d = RD_W'(edge_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      edge_q        <= '0;
      rdata_q       <= '0;
    end else begin
      sync1_q       <= key_n_i;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      edge_q        <= edge_d;
      rdata_q       <= rdata_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign key_state_o  = stable_q;
  assign irq_o        = |(edge_q & mask_q);

endmodule

// File: tb/tb_key_irq_debounce.sv
// Randomised and directed checks of key_irq_debounce against a history-window reference model.
module tb_key_irq_debounce;

  localparam int NK = 4;
  localparam int D  = 8;

  logic          clk;
  logic          reset;
  logic [NK-1:0] key_n;
  logic          irq;
  logic [NK-1:0] key_state;

  int errors;
  int checks;

  key_irq_debounce_if bus_if ();

  key_irq_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n_i    (key_n),
    .bus        (bus_if),
    .irq_o      (irq),
    .key_state_o(key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a key's accepted level flips once the synchronized pin (pin two edges ago)
  // has shown the same, different level over the last D cycles.
  logic [NK-1:0] ph [0:D+1];
  logic [NK-1:0] m_stable, m_prev, m_ecap, m_mask;
  logic [31:0]   m_rdata;
  logic          m_irq;
  assign m_irq = |(m_ecap & m_mask);

  always @(posedge clk) begin
    logic [NK-1:0] nxt, clr, edg;
    logic          v, all_eq;
    if (reset) begin
      for (int j = 0; j <= D + 1; j++) ph[j] = '0;
      m_stable = '0;
      m_prev   = '0;
      m_ecap   = '0;
      m_mask   = '0;
      m_rdata  = '0;
    end else begin
      if (bus_if.read) begin
        case (bus_if.address)
          2'd0: m_rdata = {28'b0, m_stable};
          2'd1: m_rdata = '0;
          2'd2: m_rdata = {28'b0, m_mask};
          default: m_rdata = {28'b0, m_ecap};
        endcase
      end
      nxt = m_stable;
      for (int k = 0; k < NK; k++) begin
        v = ph[1][k];
        all_eq = 1'b1;
        for (int j = 2; j <= D; j++) if (ph[j][k] != v) all_eq = 1'b0;
        if (all_eq && (v != m_stable[k])) nxt[k] = v;
      end
      clr = (bus_if.write && bus_if.address == 2'd3) ? bus_if.writedata[NK-1:0] : '0;
`ifdef KEY_IRQ_RELEASE_EDGE_EN
      edg = m_stable ^ m_prev;
`else
      edg = m_stable & ~m_prev;
`endif
      m_ecap = (m_ecap & ~clr) | edg;
      if (bus_if.write && bus_if.address == 2'd2) m_mask = bus_if.writedata[NK-1:0];
      m_prev   = m_stable;
      m_stable = nxt;
      for (int j = D + 1; j >= 1; j--) ph[j] = ph[j-1];
      ph[0] = ~key_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.address   = 2'd0;
    bus_if.writedata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_n = '1;
    bus_idle();
    repeat (3) step();
    checks++;
    if (key_state !== 4'h0) begin errors++; $display("FAIL reset_key_state got=%h want=0", key_state); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b want=0", irq); end
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got=%h want=0", bus_if.readdata); end
    reset = 1'b0;
    bus_if.read = 1'b1; bus_if.address = 2'd3;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL reset_edgecap got=%h want=0", bus_if.readdata); end
  endtask

  task automatic test_press_timing();
    key_n[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (key_state[0] !== (k == 10)) begin
        errors++; $display("FAIL press_latency cycle=%0d got=%b want=%b", k, key_state[0], (k == 10));
      end
    end
    step();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL press_irq_masked got=%b want=0", irq); end
    bus_if.read = 1'b1; bus_if.address = 2'd3;
    step();
    checks++;
    if (bus_if.readdata !== 32'h1) begin errors++; $display("FAIL press_edgecap got=%h want=1", bus_if.readdata); end
    bus_if.address = 2'd0;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== 32'h1) begin errors++; $display("FAIL press_data got=%h want=1", bus_if.readdata); end
  endtask

  task automatic test_mask_w1c();
    bus_if.write = 1'b1; bus_if.address = 2'd2; bus_if.writedata = 32'h1;
    step();
    bus_idle();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq_set got=%b want=1", irq); end
    bus_if.write = 1'b1; bus_if.address = 2'd3; bus_if.writedata = 32'h1;
    step();
    bus_idle();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_clear got=%b want=0", irq); end
    bus_if.write = 1'b1; bus_if.address = 2'd1; bus_if.writedata = 32'hFFFF_FFFF;
    step();
    bus_if.write = 1'b0; bus_if.read = 1'b1;
    step();
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL direction_ro got=%h want=0", bus_if.readdata); end
    bus_if.address = 2'd2;
    step();
    checks++;
    if (bus_if.readdata !== 32'h1) begin errors++; $display("FAIL mask_read got=%h want=1", bus_if.readdata); end
    bus_if.address = 2'd3;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL w1c_read got=%h want=0", bus_if.readdata); end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      key_n[2] = ((c % 6) == 5);
      step();
      checks++;
      if (key_state[2] !== 1'b0) begin errors++; $display("FAIL bounce_state cycle=%0d got=1 want=0", c); end
    end
    key_n[2] = 1'b1;
    repeat (3) step();
    bus_if.read = 1'b1; bus_if.address = 2'd3;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== 32'h0) begin errors++; $display("FAIL bounce_edgecap got=%h want=0", bus_if.readdata); end
  endtask

  task automatic test_collision();
    bus_if.write = 1'b1; bus_if.address = 2'd2; bus_if.writedata = 32'h9;
    key_n[3] = 1'b0;
    step();
    bus_idle();
    repeat (9) step();
    checks++;
    if (key_state[3] !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL collide_pre state=%b irq=%b want state=1 irq=0", key_state[3], irq);
    end
    bus_if.write = 1'b1; bus_if.address = 2'd3; bus_if.writedata = 32'h8;
    step();
    bus_idle();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL collide_irq got=%b want=1", irq); end
    bus_if.read = 1'b1; bus_if.address = 2'd3;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== 32'h8) begin errors++; $display("FAIL collide_edgecap got=%h want=8", bus_if.readdata); end
  endtask

  task automatic test_release();
    logic [31:0] exp_ecap;
`ifdef KEY_IRQ_RELEASE_EDGE_EN
    exp_ecap = 32'h9;
`else
    exp_ecap = 32'h8;
`endif
    key_n[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (key_state[0] !== (k < 10)) begin
        errors++; $display("FAIL release_latency cycle=%0d got=%b want=%b", k, key_state[0], (k < 10));
      end
    end
    step();
    bus_if.read = 1'b1; bus_if.address = 2'd3;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== exp_ecap) begin
      errors++; $display("FAIL release_edgecap got=%h want=%h", bus_if.readdata, exp_ecap);
    end
  endtask

  task automatic test_reset_midcount();
    key_n = '1;
    repeat (12) step();
    key_n[1] = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if (key_state !== 4'h0 || irq !== 1'b0 || bus_if.readdata !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs state=%h irq=%b rd=%h want all 0", key_state, irq, bus_if.readdata);
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (key_state[1] !== (k == 10)) begin
        errors++; $display("FAIL midreset_latency cycle=%0d got=%b want=%b", k, key_state[1], (k == 10));
      end
    end
    step();
    bus_if.read = 1'b1; bus_if.address = 2'd3;
    step();
    bus_idle();
    checks++;
    if (bus_if.readdata !== 32'h2) begin errors++; $display("FAIL midreset_edgecap got=%h want=2", bus_if.readdata); end
  endtask

  task automatic test_random();
    int hold [NK];
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_n[k] = 1'($urandom_range(0, 1));
          hold[k]  = $urandom_range(1, 14);
        end else begin
          hold[k]--;
        end
      end
      bus_idle();
      case ($urandom_range(0, 3))
        1: begin bus_if.read = 1'b1; bus_if.address = 2'($urandom_range(0, 3)); end
        2: begin
          bus_if.write = 1'b1; bus_if.address = 2'($urandom_range(0, 3)); bus_if.writedata = $urandom;
        end
        3: begin
          bus_if.read = 1'b1; bus_if.write = 1'b1;
          bus_if.address = 2'($urandom_range(2, 3)); bus_if.writedata = $urandom;
        end
        default: ;
      endcase
      step();
      checks++;
      if (key_state !== m_stable) begin
        errors++; $display("FAIL rand_state cycle=%0d got=%h want=%h", c, key_state, m_stable);
      end
      checks++;
      if (irq !== m_irq) begin errors++; $display("FAIL rand_irq cycle=%0d got=%b want=%b", c, irq, m_irq); end
      checks++;
      if (bus_if.readdata !== m_rdata) begin
        errors++; $display("FAIL rand_readdata cycle=%0d got=%h want=%h", c, bus_if.readdata, m_rdata);
      end
    end
    bus_idle();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_press_timing();
    test_mask_w1c();
    test_bounce();
    test_collision();
    test_release();
    test_reset_midcount();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
